// File: rtl/regfile_pkg.sv
// Shared register-file constants and address qualification used by the
// register file, decode and writeback.
package regfile_pkg;

  localparam int ZERO_REG      = 0;
  localparam int REGFILE_XLEN  = 32;
  localparam int REGFILE_NREGS = 32;

  // An address names a real, writable register: not x0 and inside the file.
  function automatic logic regfile_addr_valid(input int addr, input int nregs);
    return (addr != ZERO_REG) && (addr < nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register plus a
// registered, incrementally maintained count of busy registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = REGFILE_NREGS,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                clear_valid,
  input  logic [AW-1:0]       clear_addr,
  input  logic [NREAD*AW-1:0] read_address,
  output logic [NREAD-1:0]    busy_raw,
  output logic [AW:0]         busy_count
);

  localparam int         NSLOT   = 1 << AW;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [NSLOT-1:0] busy_q;
  logic             set_valid;
  logic             set_new;
  logic             clr_old;

  assign set_valid = issue_valid && regfile_addr_valid(32'(issue_rd), NREGS);
  // Count only real transitions; a clear overridden by a same-register set is no transition.
  assign set_new   = set_valid && !busy_q[issue_rd];
  assign clr_old   = clear_valid && busy_q[clear_addr]
                     && !(set_valid && (issue_rd == clear_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      // NOTE: non-blocking updates; the later set overrides the earlier clear on the same bit.
      if (clear_valid) busy_q[clear_addr] <= 1'b0;
      if (set_valid)   busy_q[issue_rd]   <= 1'b1;
      case ({set_new, clr_old})
        2'b10:   busy_count <= busy_count + CNT_ONE;
        2'b01:   busy_count <= busy_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_raw = '0;
    for (int i = 0; i < NREAD; i++) begin
      busy_raw[i] = busy_q[read_address[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write-to-read bypass
// and an integrated busy-bit scoreboard for the hazard unit.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = REGFILE_XLEN,
  parameter  int NREGS  = REGFILE_NREGS,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [AW-1:0]         write_address,
  input  logic [XLEN-1:0]       write_data,
  input  logic [NREAD*AW-1:0]   read_address,
  output logic [NREAD*XLEN-1:0] read_data,
  output logic [NREAD-1:0]      read_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [AW:0]           busy_count
);

  localparam int NSLOT  = 1 << AW;
  localparam bit BYP_EN = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NSLOT];
  logic             wr_valid;
  logic [NREAD-1:0] busy_raw;

  assign wr_valid = write_enable && regfile_addr_valid(32'(write_address), NREGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every entry is reset, so this array must map to flops rather than a RAM macro.
      for (int r = 0; r < NSLOT; r++) regs[r] <= '0;
    end else if (wr_valid) begin
      regs[write_address] <= write_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .clear_valid  (wr_valid),
    .clear_addr   (write_address),
    .read_address (read_address),
    .busy_raw     (busy_raw),
    .busy_count   (busy_count)
  );

  // Bypass is suppressed under reset so every port reads zero while rst is high.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves an output unassigned (no latch).
    read_data = '0;
    read_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (regfile_addr_valid(32'(read_address[i*AW +: AW]), NREGS)) begin
        if (BYP_EN && wr_valid && !rst && (write_address == read_address[i*AW +: AW])) begin
          read_data[i*XLEN +: XLEN] = write_data;
        end else begin
          read_data[i*XLEN +: XLEN] = regs[read_address[i*AW +: AW]];
          read_busy[i]              = busy_raw[i];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file with write-to-read bypass and an integrated busy-bit scoreboard.
- Replaces the fixed 2R1W 32x32 file in the core.
- Serves decode and operand read: returns operand values and a per-port busy flag, so the hazard unit stalls without keeping its own register tracking.
- Writeback drives the write port; decode drives the issue port.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (2..64). Register 0 is hardwired to zero.
- NREAD, 2, number of combinational read ports (1..4).
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports and clears their busy flag.
- AW, $clog2(NREGS), address width. This is a localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_enable  in  1  writeback valid.
- write_address  in  AW  destination register.
- write_data  in  XLEN  writeback value.
- read_address  in  NREAD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- read_data  out  NREAD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- read_busy  out  NREAD  port i source has a pending producer.
- issue_valid  in  1  decode issues an instruction that writes a register.
- issue_rd  in  AW  destination of the issued instruction.
- busy_count  out  $clog2(NREGS)+1  number of registers currently marked busy.

Behaviour:
- Reset:
  - Asserting rst immediately and asynchronously clears all registers to 0, all busy bits to 0, and busy_count to 0.
  - read_data and read_busy are then 0 for every port.
  - Reset asserted mid-write: the write is lost.
- Valid write: a write is valid when write_enable=1, write_address!=0 and write_address<NREGS.
  - The register updates at the next rising edge.
  - Invalid writes are ignored: no state change and no busy-bit effect.
- Read, port i, combinational with zero latency:
  - Address 0 or address >= NREGS: read_data=0 and read_busy=0.
  - BYPASS=1 and a valid write to the same address this cycle: read_data=write_data and read_busy=0.
  - Otherwise: read_data is the stored value and read_busy is the stored busy bit.
- BYPASS=0: reads return the pre-write value. The write becomes visible the cycle after the edge, and busy stays set until then.
- Scoreboard, next-state per register r:
  - Set when issue_valid=1, issue_rd==r, r!=0 and r<NREGS.
  - Cleared when there is a valid write to r.
  - Simultaneous set and clear on the same r: set wins. The newer producer is outstanding, but the register value still updates.
  - Issue to r=0 has no effect.
- busy_count:
  - Registered.
  - Equals the popcount of the busy bits after each edge.
  - Updated incrementally by +1, -1 or 0 per cycle. Never double-counts a set of an already-busy bit or a clear of an idle bit.
  - Range is 0..NREGS-1.
- Multiple read ports may share one address, and each returns an identical result.
- No write-port conflicts are possible: single write port.

Decomposition:
- Shared package regfile_pkg:
  - Constant ZERO_REG=0.
  - Default XLEN and NREGS constants shared with decode and writeback.
  - Function regfile_addr_valid(addr, nregs).
- One sub-module, regfile_scoreboard:
  - Holds the busy bits and busy_count.
  - Inputs: issue port, write clear, read addresses.
  - Outputs: raw busy per read port.
  - The top module applies bypass masking and data muxing.

Test Plan:
- Reset with all registers previously written (e.g. x5=0xDEADBEEF), then assert rst mid-cycle -> read_data for x5 goes to 0 with no clock edge; busy_count=0.
- Write x7=0x12345678 with BYPASS=1 while port 1 reads x7 in the same cycle -> port 1 returns 0x12345678 immediately. With BYPASS=0 it returns the old value 0 until after the edge.
- Issue rd=9, then read x9 -> read_busy=1 and busy_count=1. Later write x9=0xA5 with the read in the same cycle -> read_busy=0 (bypass); after the edge busy_count=0.
- Same cycle: issue rd=3 and valid write to x3=0x55 -> after the edge x3=0x55, busy[3]=1, busy_count unchanged if x3 was already busy, +1 if it was idle.
- Write and issue to x0 with 0xFFFFFFFF -> read x0 gives 0, read_busy=0, busy_count unchanged. With NREGS=24, an address of 30 on write, issue and read -> ignored; reads return 0.
- NREAD=4, all ports reading x12 after x12=0xCAFE0001 -> all four return 0xCAFE0001. Then issue rd 1..31 back-to-back -> busy_count reaches 31 and saturates logically (no wrap); re-issuing a busy register does not increment.
